// File: rtl/window_motor_driver.sv
// Purpose: window motor H-bridge driver with debounced limits, dead-time interlock and travel timeout.
// Latency: command -> busy next cycle, motor after DEADTIME more; limit -> debounced after 2+DEBOUNCE_CYCLES.
// Backpressure: none; commands are level-sampled and ignored unless the current state accepts them.
module window_motor_driver #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DEADTIME        = 8,
   parameter int TRAVEL_TIMEOUT  = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic open_cw,
   input  logic close_ccw,
   input  logic limit_open,
   input  logic limit_closed,
   output logic motor_cw,
   output logic motor_ccw,
   output logic at_open,
   output logic at_closed,
   output logic busy,
   output logic fault
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DTW = $clog2(DEADTIME + 1);
   localparam int RNW = $clog2(TRAVEL_TIMEOUT + 1);

   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DTW-1:0] DT_LAST = DTW'(DEADTIME - 1);
   localparam logic [RNW-1:0] RN_LAST = RNW'(TRAVEL_TIMEOUT - 1);

   localparam logic DIR_CW  = 1'b0;
   localparam logic DIR_CCW = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEAD,
      ST_RUN_CW,
      ST_RUN_CCW,
      ST_FAULT
   } state_t;

   // Limit conditioning: index 0 is the open switch, index 1 the closed switch.
   logic [1:0]     sync1_q;
   logic [1:0]     sync2_q;
   logic [1:0]     deb_q;
   logic [DBW-1:0] db_cnt_q [2];

   state_t         state_q, state_d;
   logic           dir_q, dir_d;
   logic [DTW-1:0] dead_cnt_q, dead_cnt_d;
   logic [RNW-1:0] run_cnt_q, run_cnt_d;

   // Synchronize raw limits, then accept a new level only after it has persisted
   // for DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q <= {limit_closed, limit_open};
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
               deb_q[i]    <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // State, latched direction and the dead/run counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         dir_q      <= DIR_CW;
         dead_cnt_q <= '0;
         run_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         dead_cnt_q <= dead_cnt_d;
         run_cnt_q  <= run_cnt_d;
      end
   end

   // Next-state logic; both-limits-active overrides everything, and inside a run
   // the order is limit reached, then reversal, then timeout.
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      dead_cnt_d = dead_cnt_q;
      run_cnt_d  = run_cnt_q;
      if (deb_q[0] && deb_q[1]) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (open_cw && !close_ccw && !deb_q[0]) begin
                  state_d    = ST_DEAD;
                  dir_d      = DIR_CW;
                  dead_cnt_d = '0;
               end else if (close_ccw && !open_cw && !deb_q[1]) begin
                  state_d    = ST_DEAD;
                  dir_d      = DIR_CCW;
                  dead_cnt_d = '0;
               end
            end
            ST_DEAD: begin
               if (dir_q == DIR_CW && close_ccw && !open_cw) begin
                  dir_d      = DIR_CCW;
                  dead_cnt_d = '0;
               end else if (dir_q == DIR_CCW && open_cw && !close_ccw) begin
                  dir_d      = DIR_CW;
                  dead_cnt_d = '0;
               end else if (dead_cnt_q == DT_LAST) begin
                  state_d   = (dir_q == DIR_CCW) ? ST_RUN_CCW : ST_RUN_CW;
                  run_cnt_d = '0;
               end else begin
                  dead_cnt_d = dead_cnt_q + 1'b1;
               end
            end
            ST_RUN_CW: begin
               if (deb_q[0]) begin
                  state_d = ST_IDLE;
               end else if (close_ccw) begin
                  state_d    = ST_DEAD;
                  dir_d      = DIR_CCW;
                  dead_cnt_d = '0;
               end else if (run_cnt_q == RN_LAST) begin
                  state_d = ST_FAULT;
               end else begin
                  run_cnt_d = run_cnt_q + 1'b1;
               end
            end
            ST_RUN_CCW: begin
               if (deb_q[1]) begin
                  state_d = ST_IDLE;
               end else if (open_cw) begin
                  state_d    = ST_DEAD;
                  dir_d      = DIR_CW;
                  dead_cnt_d = '0;
               end else if (run_cnt_q == RN_LAST) begin
                  state_d = ST_FAULT;
               end else begin
                  run_cnt_d = run_cnt_q + 1'b1;
               end
            end
            ST_FAULT: begin
               state_d = ST_FAULT;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode from registered state only, so the two drives can never overlap.
   assign motor_cw  = (state_q == ST_RUN_CW);
   assign motor_ccw = (state_q == ST_RUN_CCW);
   assign busy      = (state_q == ST_DEAD) || (state_q == ST_RUN_CW) || (state_q == ST_RUN_CCW);
   assign fault     = (state_q == ST_FAULT);
   assign at_open   = deb_q[0];
   assign at_closed = deb_q[1];

endmodule

// File: doc/window_motor_driver.md
# window_motor_driver

Actuator-side controller that consumes the `open_cw` / `close_ccw` command strobes produced by the window state machine and drives the window motor. It adds debounced end-of-travel limit switches, a dead-time interlock on every start and reversal, and a travel timeout with a latched fault. It sits between the window FSM and the motor H-bridge pins.

## Interface

- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a synchronized limit input changes its debounced value. Must be ≥ 1.
- `DEADTIME`, default 8: cycles with both motor outputs low before any motor output is energized. Must be ≥ 1.
- `TRAVEL_TIMEOUT`, default 1000: maximum cycles in a run state before a fault is declared. Must be ≥ 2.
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `open_cw`  in  1  open command, sampled each cycle.
- `close_ccw`  in  1  close command, sampled each cycle.
- `limit_open`  in  1  raw, asynchronous fully-open switch, active high.
- `limit_closed`  in  1  raw, asynchronous fully-closed switch, active high.
- `motor_cw`  out  1  H-bridge drive, open direction.
- `motor_ccw`  out  1  H-bridge drive, close direction.
- `at_open`  out  1  debounced `limit_open`.
- `at_closed`  out  1  debounced `limit_closed`.
- `busy`  out  1  high in DEAD, RUN_CW and RUN_CCW.
- `fault`  out  1  high in FAULT.

## Operation

**Limit conditioning**
- Each limit input passes through a 2-flop synchronizer.
- It then passes through a per-input stability counter of width $clog2(DEBOUNCE_CYCLES+1).
- The debounced value takes the synchronized value only after that value has differed from the current debounced value for DEBOUNCE_CYCLES consecutive cycles.
- Any bounce restarts the count.

**States**
- IDLE: both motor outputs low.
  - `open_cw` & !`close_ccw` & !`at_open` → DEAD, direction CW.
  - `close_ccw` & !`open_cw` & !`at_closed` → DEAD, direction CCW.
  - Both commands high, or the command's target limit already active → ignored; stay in IDLE.
- DEAD: both motor outputs low. The dead counter counts DEADTIME cycles, then → RUN_CW or RUN_CCW per the latched direction. A command for the opposite direction during DEAD re-latches the direction and restarts the dead counter.
- RUN_CW: `motor_cw`=1.
  - `at_open` → IDLE.
  - `close_ccw` → DEAD, direction CCW (reversal).
  - `open_cw` is ignored.
  - The run counter reaching TRAVEL_TIMEOUT → FAULT.
- RUN_CCW: symmetric to RUN_CW, using `at_closed` and `open_cw`.
- FAULT: both motor outputs low, `fault`=1. Only `reset` exits FAULT.
- Global: `at_open` & `at_closed` both high, in any state → FAULT on the next edge. This has priority over all other transitions.

**Priority inside a RUN state:** global fault > limit reached > reversal command > timeout.

**Invariants**
- `motor_cw` & `motor_ccw` is never 1 in the same cycle.
- Every transition into a RUN state passes through DEAD.

**Reset**
- State → IDLE; all counters, synchronizers and debounced values → 0.
- All outputs are 0 in the cycle after reset is sampled, including reset asserted mid-run.

## Timing

- Motor outputs and `busy` / `fault` are decoded from the registered state only, with no input-to-output combinational path.
- `open_cw` high in cycle N (IDLE): `busy`=1 from cycle N+1; `motor_cw`=1 from cycle N+1+DEADTIME.
- Reversal: command in cycle N → motor off from cycle N+1, opposite motor on from cycle N+1+DEADTIME.
- Limit latency:
  - Raw change stable from cycle N → debounced output changes in cycle N+2+DEBOUNCE_CYCLES.
  - Motor drops in the following cycle.
- Timeout: the run counter clears on RUN entry. The motor stays on for exactly TRAVEL_TIMEOUT cycles, then `fault`=1 on the next cycle.
- Commands are level-sampled; a 1-cycle strobe is sufficient. A held command re-triggers only from IDLE.

## Test plan

Use DEBOUNCE_CYCLES=4, DEADTIME=3, TRAVEL_TIMEOUT=50.

1. Reset, then a 1-cycle `open_cw` pulse at cycle 10 → `busy`=1 at cycle 11; `motor_cw`=1 at cycle 14. Assert `limit_open` at cycle 30 → `at_open`=1 at cycle 36; `motor_cw`=0 at cycle 37; IDLE.
2. From the open position, `close_ccw` pulse → `motor_ccw` on after 3 dead cycles. At RUN+5, pulse `open_cw` → `motor_ccw`=0 next cycle, 3 cycles with both low, then `motor_cw`=1. Check the two motor outputs are never high together.
3. `limit_closed` toggling every 2 cycles for 20 cycles, then held high → `at_closed` rises only 6 cycles after the final stable level; no earlier change.
4. `open_cw` with no limit ever asserted → `motor_cw` high for exactly 50 cycles, then `fault`=1 and motor outputs low. Further commands are ignored until `reset`, after which all outputs are 0.
5. Both limits high for ≥6 cycles while in RUN_CW → FAULT, motor off.
6. `open_cw` and `close_ccw` high together in IDLE → no state change. `open_cw` while `at_open`=1 → ignored, `busy` stays 0.
